// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES constants, round transforms and per-stage key expansion
package aes_pkg;

  typedef logic [31:0] word_t;
  // Key-schedule window: word k of the window sits at index k; words >= NK stay zero.
  typedef logic [7:0][31:0] win_t;
  typedef logic [3:0][31:0] quad_t;

  // Row 0 of the table is the most significant byte, so S(x) = SBOX[~x].
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [7:0] RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[~b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[8*j +: 8] = sbox(s[8*j +: 8]);
    return r;
  endfunction

  // Byte j (MSB first) is row j%4, column j/4; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int j = 0; j < 16; j++)
      r[127-8*j -: 8] = s[127-8*((j % 4) + 4*(((j / 4) + (j % 4)) % 4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  // The four schedule words following the window entering round rnd (window starts at w[4*(rnd-1)]).
  function automatic quad_t key_next(input win_t win, input int nk, input int rnd);
    logic [11:0][31:0] ext;
    quad_t nw;
    word_t tmp;
    int i;
    ext = '0;
    ext[7:0] = win;
    for (int k = 0; k < 4; k++) begin
      i = 4*(rnd - 1) + nk + k;
      tmp = ext[4'(nk + k - 1)];
      if (i % nk == 0) tmp = sub_word(rot_word(tmp)) ^ {RCON[4'(i / nk)], 24'h0};
      else if (nk > 6 && i % nk == 4) tmp = sub_word(tmp);
      ext[4'(nk + k)] = ext[4'(k)] ^ tmp;
      nw[k] = ext[4'(nk + k)];
    end
    return nw;
  endfunction

  function automatic win_t shift_window(input win_t win, input quad_t nw, input int nk);
    logic [11:0][31:0] ext;
    win_t r;
    ext = '0;
    ext[7:0] = win;
    for (int k = 0; k < 4; k++) ext[4'(nk + k)] = nw[k];
    for (int k = 0; k < 8; k++) r[k] = ext[4'(k + 4)];
    return r;
  endfunction

endpackage

// File: rtl/aes_round.sv
// rtl/aes_round.sv - one registered AES round with its own round-key generation
module aes_round
  import aes_pkg::*;
#(
  parameter int NK    = 4,
  parameter int ROUND = 1,
  parameter bit FINAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [127:0] i_state,
  input  win_t         i_win,
  output logic         o_valid,
  output logic [127:0] o_state,
  output win_t         o_win
);

  quad_t        w_new;
  win_t         w_win_next;
  logic [127:0] w_rkey;
  logic [127:0] w_sr;
  logic [127:0] w_mix;

  logic         r_valid;
  logic [127:0] r_state;
  win_t         r_win;

  assign w_new      = key_next(i_win, NK, ROUND);
  assign w_win_next = shift_window(i_win, w_new, NK);
  // The shifted window starts with this round's key words.
  assign w_rkey     = {w_win_next[0], w_win_next[1], w_win_next[2], w_win_next[3]};
  assign w_sr       = shift_rows(sub_bytes(i_state));
  assign w_mix      = FINAL ? w_sr : mix_columns(w_sr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_state <= '0;
      r_win   <= '0;
    end else begin
      r_valid <= i_valid;
      r_state <= w_mix ^ w_rkey;
      r_win   <= w_win_next;
    end
  end

  assign o_valid = r_valid;
  assign o_state = r_state;
  assign o_win   = r_win;

endmodule

// File: rtl/aes_cipher.sv
// rtl/aes_cipher.sv - fully pipelined AES encryption, one block per clock
module aes_cipher
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic [0:127]    in,
  input  logic [0:32*NK-1] key,
  output logic [0:127]    out,
  output logic            valid_out
);

  localparam int NKB = 32 * NK;

  if (!((NK == 4 || NK == 6 || NK == 8) && NR == NK + 6)) begin : g_bad_params
    $error("aes_cipher: NK must be 4, 6 or 8 and NR must equal NK+6");
  end

  logic [NKB-1:0] w_key;
  logic [127:0]   w_in;
  win_t           w_key_win;

  logic           r_valid;
  logic [127:0]   r_state;
  win_t           r_win;

  logic           w_valid [0:NR];
  logic [127:0]   w_state [0:NR];
  win_t           w_win   [0:NR];

  assign w_key = key;
  assign w_in  = in;

  always_comb begin
    w_key_win = '0;
    for (int k = 0; k < NK; k++) w_key_win[k] = w_key[NKB-1-32*k -: 32];
  end

  // Stage 0: whitening with round key 0 and capture of the full key window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_state <= '0;
      r_win   <= '0;
    end else begin
      r_valid <= valid_in;
      r_state <= w_in ^ w_key[NKB-1 -: 128];
      r_win   <= w_key_win;
    end
  end

  assign w_valid[0] = r_valid;
  assign w_state[0] = r_state;
  assign w_win[0]   = r_win;

  for (genvar r = 1; r <= NR; r++) begin : g_round
    aes_round #(
      .NK   (NK),
      .ROUND(r),
      .FINAL(r == NR)
    ) u_round (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_valid(w_valid[r-1]),
      .i_state(w_state[r-1]),
      .i_win  (w_win[r-1]),
      .o_valid(w_valid[r]),
      .o_state(w_state[r]),
      .o_win  (w_win[r])
    );
  end

  assign out       = w_state[NR];
  assign valid_out = w_valid[NR];

endmodule

// File: tb/tb_aes_cipher.sv
// tb/tb_aes_cipher.sv - randomized and known-answer bench for aes_cipher
module tb_aes_cipher;

  localparam int LAT_A = 11;
  localparam int LAT_B = 15;
  localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         va, vb, voa, vob;
  logic [127:0] pa, pb, ka, oa, ob;
  logic [255:0] kb;

  aes_cipher dut_a (
    .clk(clk), .rst_n(rst_n), .valid_in(va), .in(pa), .key(ka), .out(oa), .valid_out(voa)
  );

  aes_cipher #(.NK(8), .NR(14)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_in(vb), .in(pb), .key(kb), .out(ob), .valid_out(vob)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int g       = 0;

  logic [7:0]   sb   [0:255];
  logic         ha_v [0:4095];
  logic [127:0] ha_d [0:4095];
  logic         hb_v [0:4095];
  logic [127:0] hb_d [0:4095];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8), then the affine map.
  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  // Reference encryption; key is left-aligned in k (first nk words used).
  function automatic logic [127:0] ref_enc(input logic [255:0] k, input int nk, input logic [127:0] pt);
    logic [31:0]  w [0:63];
    logic [7:0]   s [0:15];
    logic [7:0]   t [0:15];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) tmp = subw(tmp);
      w[i] = w[i-nk] ^ tmp;
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int j = 0; j < 16; j++) t[j] = sb[s[(j%4) + 4*(((j/4) + (j%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        if (r == nr) begin
          for (int q = 0; q < 4; q++) s[4*c+q] = t[4*c+q];
        end else begin
          s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
          s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
        end
      end
      for (int j = 0; j < 16; j++) s[j] ^= w[4*r + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic exp_va();
    return (g >= LAT_A) ? ha_v[g-LAT_A] : 1'b0;
  endfunction
  function automatic logic [127:0] exp_da();
    return (g >= LAT_A) ? ha_d[g-LAT_A] : 128'h0;
  endfunction
  function automatic logic exp_vb();
    return (g >= LAT_B) ? hb_v[g-LAT_B] : 1'b0;
  endfunction
  function automatic logic [127:0] exp_db();
    return (g >= LAT_B) ? hb_d[g-LAT_B] : 128'h0;
  endfunction

  // Drive one cycle on both instances, record the model's expectation, step past the edge.
  task automatic cycle(input logic v_a, input logic [127:0] p_a, input logic [127:0] k_a,
                       input logic v_b, input logic [127:0] p_b, input logic [255:0] k_b);
    va = v_a; pa = p_a; ka = k_a;
    vb = v_b; pb = p_b; kb = k_b;
    if (rst_n) begin
      ha_v[g] = v_a;
      ha_d[g] = v_a ? ref_enc({k_a, 128'h0}, 4, p_a) : 128'h0;
      hb_v[g] = v_b;
      hb_d[g] = v_b ? ref_enc(k_b, 8, p_b) : 128'h0;
    end
    @(posedge clk);
    #1;
    if (rst_n) g++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, rnd128(), rnd128(), 1'b1, rnd128(), {rnd128(), rnd128()});
      n_tests++;
      if (voa !== 1'b0 || oa !== 128'h0 || vob !== 1'b0 || ob !== 128'h0) begin
        n_fail++;
        $display("FAIL reset_hold: a valid=%b out=%h b valid=%b out=%h, required all zero", voa, oa, vob, ob);
      end
    end
    g = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [127:0] vpt [0:4];
    logic [127:0] vct [0:4];
    vpt = '{128'h000102030405060708090a0b0c0d0e0f, 128'h0f0e0d0c0b0a09080706050403020100,
            128'h00000101030307070f0f1f1f3f3f7f7f, 128'h0,
            128'h00112233445566778899aabbccddeeff};
    vct = '{128'h0a940bb5416ef045f1c39458c653ea5a, 128'h20a9f992b44c5be8041ffcdc6cae996a,
            128'hb7ea90af536c82a8c8df97106b978f5a, 128'hc6a13b37878f5b826f4f8162a1c8d879,
            128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    for (int i = 0; i < 5 + LAT_A; i++) begin
      if (i < 5) cycle(1'b1, vpt[i], K128, 1'b0, 128'h0, 256'h0);
      else       cycle(1'b0, rnd128(), rnd128(), 1'b0, 128'h0, 256'h0);
      n_tests++;
      if (g >= LAT_A && g < LAT_A + 5) begin
        if (voa !== 1'b1 || oa !== vct[g-LAT_A]) begin
          n_fail++;
          $display("FAIL known_answer_%0d: valid=%b out=%h, required valid=1 out=%h", g-LAT_A, voa, oa, vct[g-LAT_A]);
        end
      end else if (voa !== 1'b0) begin
        n_fail++;
        $display("FAIL known_answer_gap cycle %0d: valid=%b, required 0", g, voa);
      end
    end
  endtask

  task automatic test_aes256();
    int g0;
    g0 = g;
    for (int i = 0; i < LAT_B + 3; i++) begin
      cycle(1'b0, 128'h0, 128'h0, (i == 0), 128'h00112233445566778899aabbccddeeff,
            256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
      n_tests++;
      if (g - g0 == LAT_B) begin
        if (vob !== 1'b1 || ob !== 128'h8ea2b7ca516745bfeafc49904b496089) begin
          n_fail++;
          $display("FAIL aes256_vector: valid=%b out=%h, required valid=1 out=8ea2b7ca516745bfeafc49904b496089", vob, ob);
        end
      end else if (vob !== 1'b0) begin
        n_fail++;
        $display("FAIL aes256_latency cycle %0d: valid=%b, required 0", g - g0, vob);
      end
    end
  endtask

  task automatic test_back_to_back_random();
    logic v1, v2;
    for (int i = 0; i < 200 + LAT_B; i++) begin
      v1 = (i < 200) && ($urandom_range(3) != 0);
      v2 = (i < 200) && ($urandom_range(3) != 0);
      cycle(v1, rnd128(), rnd128(), v2, rnd128(), {rnd128(), rnd128()});
      n_tests++;
      if (voa !== exp_va() || (exp_va() && oa !== exp_da())) begin
        n_fail++;
        $display("FAIL random_aes128 cycle %0d: valid=%b out=%h, required valid=%b out=%h", g, voa, oa, exp_va(), exp_da());
      end
      n_tests++;
      if (vob !== exp_vb() || (exp_vb() && ob !== exp_db())) begin
        n_fail++;
        $display("FAIL random_aes256 cycle %0d: valid=%b out=%h, required valid=%b out=%h", g, vob, ob, exp_vb(), exp_db());
      end
    end
  endtask

  task automatic test_key_alternate();
    for (int i = 0; i < 24 + LAT_A; i++) begin
      cycle((i < 24) && (i % 5 != 3), rnd128(), (i % 2 == 1) ? K128 : 128'h0, 1'b0, 128'h0, 256'h0);
      n_tests++;
      if (voa !== exp_va() || (exp_va() && oa !== exp_da())) begin
        n_fail++;
        $display("FAIL key_alternate cycle %0d: valid=%b out=%h, required valid=%b out=%h", g, voa, oa, exp_va(), exp_da());
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [127:0] sp [0:11];
    logic [127:0] sk [0:11];
    for (int i = 0; i < 12; i++) begin
      sp[i] = rnd128();
      sk[i] = rnd128();
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 12 + LAT_A; i++) begin
        if (i < 12) cycle(1'b1, sp[i], sk[i], 1'b0, 128'h0, 256'h0);
        else        cycle(1'b0, 128'h0, 128'h0, 1'b0, 128'h0, 256'h0);
        n_tests++;
        if (voa !== exp_va() || (exp_va() && oa !== exp_da())) begin
          n_fail++;
          $display("FAIL replay_pass%0d cycle %0d: valid=%b out=%h, required valid=%b out=%h", pass, g, voa, oa, exp_va(), exp_da());
        end
        // Partway into the first pass, abort the stream with a reset and start over.
        if (pass == 0 && i == 7) begin
          rst_n = 1'b0;
          for (int r = 0; r < 2; r++) begin
            cycle(1'b1, rnd128(), rnd128(), 1'b0, 128'h0, 256'h0);
            n_tests++;
            if (voa !== 1'b0 || oa !== 128'h0) begin
              n_fail++;
              $display("FAIL mid_reset_hold: valid=%b out=%h, required valid=0 out=0", voa, oa);
            end
          end
          g = 0;
          rst_n = 1'b1;
          break;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    va = 1'b0; vb = 1'b0; pa = '0; pb = '0; ka = '0; kb = '0;
    init_sbox();
    test_reset();
    test_vectors();
    test_aes256();
    test_back_to_back_random();
    test_key_alternate();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
